// File: rtl/keeper_ctl_pkg.sv
// Shared game definitions: keeper controller state encoding and default geometry.
package keeper_ctl_pkg;

  typedef enum logic [2:0] {
    KS_IDLE   = 3'd0,
    KS_ARMED  = 3'd1,
    KS_DIVE   = 3'd2,
    KS_HOLD   = 3'd3,
    KS_RETURN = 3'd4
  } keeper_state_t;

  localparam int KEEPER_X_MIN    = 112;
  localparam int KEEPER_X_MAX    = 712;
  localparam int KEEPER_X_CENTER = 412;
  localparam int KEEPER_STEP     = 8;

endpackage

// File: rtl/keeper_ctl_lfsr16.sv
// 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seeded 16'hACE1 on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_d, q_q;

  always_comb begin
    q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 16'hACE1;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/keeper_ctl.sv
// Goalkeeper position sequencer: react, dive, hold, return, all stepped on vblank start.
// Define KEEPER_RANDOM_EN to have the keeper guess its target from an LFSR.
module keeper_ctl
  import keeper_ctl_pkg::*;
#(
  parameter int X_MIN        = KEEPER_X_MIN,
  parameter int X_MAX        = KEEPER_X_MAX,
  parameter int X_CENTER     = KEEPER_X_CENTER,
  parameter int STEP         = KEEPER_STEP,
  parameter int REACT_FRAMES = 4,
  parameter int HOLD_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       shot_start,
  input  logic [9:0] shot_target_x,
  input  logic       round_reset,
  output logic [9:0] keeper_x_pos,
  output logic       keeper_busy,
  output logic       keeper_done,
  output logic [2:0] keeper_state
);

  localparam int CNT_MAX = (HOLD_FRAMES > REACT_FRAMES) ? HOLD_FRAMES : REACT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  REACT_LAST = CNT_W'(REACT_FRAMES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [9:0]        XMIN_C     = 10'(X_MIN);
  localparam logic [9:0]        XMAX_C     = 10'(X_MAX);
  localparam logic [9:0]        XCTR_C     = 10'(X_CENTER);
  localparam logic signed [10:0] STEP_S    = 11'(STEP);
  localparam logic [10:0]       STEP_U     = 11'(STEP);

  function automatic logic [9:0] clamp_x(input logic [10:0] v);
    if (v < {1'b0, XMIN_C})      return XMIN_C;
    else if (v > {1'b0, XMAX_C}) return XMAX_C;
    else                         return v[9:0];
  endfunction

  function automatic logic within_step(input logic [9:0] pos, input logic [9:0] tgt);
    logic signed [10:0] diff;
    diff = signed'({1'b0, tgt}) - signed'({1'b0, pos});
    return (diff <= STEP_S) && (diff >= -STEP_S);
  endfunction

  // Distance > STEP guarantees the sum/difference stays inside 0..1023.
  function automatic logic [9:0] step_x(input logic [9:0] pos, input logic [9:0] tgt);
    logic [10:0] nxt;
    if (within_step(pos, tgt)) return tgt;
    if (tgt > pos) nxt = {1'b0, pos} + STEP_U;
    else           nxt = {1'b0, pos} - STEP_U;
    return clamp_x(nxt);
  endfunction

  logic [9:0] shot_src;

`ifdef KEEPER_RANDOM_EN
  logic [15:0] lfsr;
  logic        unused_bits;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign shot_src    = lfsr[9:0];
  assign unused_bits = ^{shot_target_x, lfsr[15:10]};
`else
  assign shot_src = shot_target_x;
`endif

  keeper_state_t    state_d, state_q;
  logic [9:0]       pos_d, pos_q;
  logic [9:0]       tgt_d, tgt_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             pend_d, pend_q;
  logic             done_d, done_q;
  logic             busy_d, busy_q;
  logic             vblnk_q;
  logic             tick;

  always_comb begin
    tick    = vblnk & ~vblnk_q;
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | round_reset;
    done_d  = 1'b0;

    if (tick && pend_d) begin
      state_d = KS_IDLE;
      pos_d   = XCTR_C;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        KS_IDLE: begin
          if (shot_start && !pend_d) begin
            tgt_d   = clamp_x({1'b0, shot_src});
            cnt_d   = '0;
            state_d = KS_ARMED;
          end
        end
        KS_ARMED: begin
          if (tick) begin
            if (cnt_q == REACT_LAST) begin
              state_d = KS_DIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        KS_DIVE: begin
          if (tick) begin
            pos_d = step_x(pos_q, tgt_q);
            if (within_step(pos_q, tgt_q)) begin
              state_d = KS_HOLD;
              cnt_d   = '0;
            end
          end
        end
        KS_HOLD: begin
          if (tick) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = KS_RETURN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        KS_RETURN: begin
          if (tick) begin
            pos_d = step_x(pos_q, XCTR_C);
            if (within_step(pos_q, XCTR_C)) begin
              state_d = KS_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = KS_IDLE;
      endcase
    end

    busy_d = (state_d != KS_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KS_IDLE;
      pos_q   <= XCTR_C;
      tgt_q   <= XCTR_C;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      vblnk_q <= vblnk;
    end
  end

  assign keeper_x_pos = pos_q;
  assign keeper_busy  = busy_q;
  assign keeper_done  = done_q;
  assign keeper_state = state_q;

endmodule

// File: tb/tb_keeper_ctl.sv
// Self-checking bench for keeper_ctl: vector table, corner sequences, randomized shots vs a trajectory model.
module tb_keeper_ctl;

  localparam int XMIN = 112;
  localparam int XMAX = 712;
  localparam int XCTR = 412;
  localparam int STP  = 8;
  localparam int REACT = 4;
  localparam int HOLD  = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk;
  logic       shot_start;
  logic [9:0] shot_target_x;
  logic       round_reset;
  logic [9:0] keeper_x_pos;
  logic       keeper_busy;
  logic       keeper_done;
  logic [2:0] keeper_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keeper_ctl dut (
    .clk           (clk),
    .rst           (rst),
    .vblnk         (vblnk),
    .shot_start    (shot_start),
    .shot_target_x (shot_target_x),
    .round_reset   (round_reset),
    .keeper_x_pos  (keeper_x_pos),
    .keeper_busy   (keeper_busy),
    .keeper_done   (keeper_done),
    .keeper_state  (keeper_state)
  );

  // Reference pseudo-random source, stepped once per clock like the keeper's guess generator.
  logic [15:0] ref_lfsr;
  always @(posedge clk) begin
    if (rst) ref_lfsr <= 16'hACE1;
    else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  typedef struct {
    int tx;
    int exp_tgt;
    int exp_dive_ticks;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int clampx(input int v);
    if (v < XMIN) return XMIN;
    if (v > XMAX) return XMAX;
    return v;
  endfunction

  function automatic int step_m(input int p, input int t);
    int d;
    d = t - p;
    if (d <= STP && d >= -STP) return t;
    return (d > 0) ? p + STP : p - STP;
  endfunction

  // One frame: raise vblnk, sample right after the tick edge, then drop vblnk and sample done again.
  task automatic frame(output int p, output int d, output int b, output int s, output int d2);
    @(negedge clk);
    vblnk = 1'b1;
    @(negedge clk);
    p = keeper_x_pos;
    d = keeper_done;
    b = keeper_busy;
    s = keeper_state;
    @(negedge clk);
    vblnk = 1'b0;
    d2 = keeper_done;
    @(negedge clk);
  endtask

  task automatic shot(input int tx, output logic [15:0] lf);
    @(negedge clk);
    shot_start    = 1'b1;
    shot_target_x = 10'(tx);
    lf            = ref_lfsr;
    @(negedge clk);
    shot_start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    round_reset = 1'b1;
    @(negedge clk);
    round_reset = 1'b0;
  endtask

  task automatic run_shot(input int tx, input int abort_at, input int exp_tgt, input int exp_dive);
    int q[$];
    int t, p, dive_ticks;
    int ap, ad, ab, as, ad2;
    logic [15:0] lf;
    shot(tx, lf);
    chk("shot_busy", keeper_busy, 1);
    chk("shot_state", keeper_state, 1);
`ifdef KEEPER_RANDOM_EN
    t = clampx(int'(lf[9:0]));
`else
    t = clampx(tx);
`endif
    for (int i = 0; i < REACT; i++) q.push_back(XCTR);
    p = XCTR;
    dive_ticks = 0;
    do begin
      p = step_m(p, t);
      q.push_back(p);
      dive_ticks++;
    end while (p != t);
    for (int i = 0; i < HOLD; i++) q.push_back(t);
    do begin
      p = step_m(p, XCTR);
      q.push_back(p);
    end while (p != XCTR);
`ifndef KEEPER_RANDOM_EN
    if (exp_tgt >= 0) begin
      chk("tbl_target", t, exp_tgt);
      chk("tbl_dive_ticks", dive_ticks, exp_dive);
      chk("tbl_dive_end_pos", q[REACT + dive_ticks - 1], exp_tgt);
    end
`endif
    for (int n = 0; n < q.size(); n++) begin
      if (n == abort_at) begin
        pulse_reset();
        frame(ap, ad, ab, as, ad2);
        chk("abort_pos", ap, XCTR);
        chk("abort_state", as, 0);
        chk("abort_busy", ab, 0);
        chk("abort_done", ad, 0);
        chk("abort_done_late", ad2, 0);
        return;
      end
      frame(ap, ad, ab, as, ad2);
      chk("traj_pos", ap, q[n]);
      chk("traj_done", ad, (n == q.size() - 1) ? 1 : 0);
      chk("traj_busy", ab, (n == q.size() - 1) ? 0 : 1);
      chk("done_one_cycle", ad2, 0);
    end
    chk("end_state", keeper_state, 0);
  endtask

  vec_t vecs[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ap, ad, ab, as, ad2;
    logic [15:0] lf;

    vecs.push_back('{500, 500, 11});
    vecs.push_back('{900, 712, 38});
    vecs.push_back('{20, 112, 38});
    vecs.push_back('{415, 415, 1});
    vecs.push_back('{412, 412, 1});
    vecs.push_back('{420, 420, 1});
    vecs.push_back('{421, 421, 2});
    vecs.push_back('{0, 112, 38});
    vecs.push_back('{1023, 712, 38});

    rst = 1'b1;
    vblnk = 1'b0;
    shot_start = 1'b0;
    shot_target_x = '0;
    round_reset = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pos", keeper_x_pos, XCTR);
    chk("rst_busy", keeper_busy, 0);
    chk("rst_done", keeper_done, 0);
    chk("rst_state", keeper_state, 0);

    for (int i = 0; i < 3; i++) begin
      frame(ap, ad, ab, as, ad2);
      chk("idle_pos", ap, XCTR);
      chk("idle_busy", ab, 0);
      chk("idle_state", as, 0);
    end

    foreach (vecs[i]) run_shot(vecs[i].tx, -1, vecs[i].exp_tgt, vecs[i].exp_dive_ticks);

`ifndef KEEPER_RANDOM_EN
    // Mid-dive: an extra shot is ignored, then round_reset re-centres on the next tick.
    shot(500, lf);
    for (int i = 0; i < REACT; i++) begin
      frame(ap, ad, ab, as, ad2);
      chk("md_react_pos", ap, XCTR);
    end
    for (int i = 1; i <= 3; i++) begin
      frame(ap, ad, ab, as, ad2);
      chk("md_dive_pos", ap, XCTR + 8 * i);
    end
    shot(900, lf);
    frame(ap, ad, ab, as, ad2);
    chk("md_ignored_shot_pos", ap, 444);
    chk("md_ignored_shot_state", as, 2);
    pulse_reset();
    frame(ap, ad, ab, as, ad2);
    chk("md_reset_pos", ap, XCTR);
    chk("md_reset_state", as, 0);
    chk("md_reset_done", ad, 0);
    chk("md_reset_busy", ab, 0);

    // round_reset coinciding with a tick during HOLD applies on that tick.
    shot(415, lf);
    repeat (REACT + 1 + 3) frame(ap, ad, ab, as, ad2);
    chk("co_hold_pos", ap, 415);
    chk("co_hold_state", as, 3);
    @(negedge clk);
    vblnk = 1'b1;
    round_reset = 1'b1;
    @(negedge clk);
    round_reset = 1'b0;
    chk("co_reset_pos", keeper_x_pos, XCTR);
    chk("co_reset_state", keeper_state, 0);
    chk("co_reset_done", keeper_done, 0);
    @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);

    // Reset and shot in the same cycle: reset wins, shot dropped.
    @(negedge clk);
    round_reset = 1'b1;
    shot_start = 1'b1;
    shot_target_x = 10'd500;
    @(negedge clk);
    round_reset = 1'b0;
    shot_start = 1'b0;
    chk("rs_same_busy", keeper_busy, 0);
    chk("rs_same_state", keeper_state, 0);
    frame(ap, ad, ab, as, ad2);
    chk("rs_same_frame_state", as, 0);
    chk("rs_same_frame_pos", ap, XCTR);

    // Shot while a reset is pending is dropped.
    pulse_reset();
    shot(600, lf);
    chk("pend_shot_busy", keeper_busy, 0);
    chk("pend_shot_state", keeper_state, 0);
    frame(ap, ad, ab, as, ad2);
    chk("pend_frame_state", as, 0);
    frame(ap, ad, ab, as, ad2);
    chk("pend_frame2_busy", ab, 0);
    chk("pend_frame2_pos", ap, XCTR);
`endif

    for (int i = 0; i < 8; i++) begin
      int tx, ab_at;
      tx = $urandom_range(0, 1023);
      ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 110)) : -1;
`ifdef KEEPER_RANDOM_EN
      tx = 0;
`endif
      run_shot(tx, ab_at, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
